// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, synchronous-read imem interface, instruction register.
// Define FETCH_SKID_EN to hold a stalled word in a skid register instead of re-reading memory.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] imem_addr,
  output logic        imem_en,
  input  logic [15:0] imem_rdata,
  output logic [15:0] ir,
  output logic [2:0]  opcode,
  output logic [15:0] ir_pc,
  output logic        ir_valid
);

  typedef enum logic [1:0] {BOOT, RUN, REDIR} state_t;

  state_t      state, state_nx;
  logic [15:0] pc_f;
  logic [15:0] fetched_pc;
  logic        hold;

`ifdef FETCH_SKID_EN
  logic [15:0] skid;
  logic        skid_valid;
`endif

  // Redirect beats stall; only a RUN-state stall freezes the pipe.
  assign hold   = (state == RUN) && stall && !redirect;
  assign opcode = ir[15:13];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= BOOT;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      BOOT, RUN, REDIR: state_nx = redirect ? REDIR : RUN;
      default:          state_nx = BOOT;
    endcase
  end

`ifdef FETCH_SKID_EN
  always_comb begin
    imem_addr = pc_f;
    imem_en   = !(hold && skid_valid);
  end
`else
  // Re-present the pending address so the word is still on imem_rdata after the stall.
  always_comb begin
    imem_addr = hold ? fetched_pc : pc_f;
    imem_en   = 1'b1;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_f       <= RESET_PC;
      fetched_pc <= RESET_PC;
      ir         <= '0;
      ir_pc      <= '0;
      ir_valid   <= 1'b0;
`ifdef FETCH_SKID_EN
      skid       <= '0;
      skid_valid <= 1'b0;
`endif
    end else if (redirect) begin
      pc_f     <= redirect_pc;
      ir_valid <= 1'b0;
`ifdef FETCH_SKID_EN
      skid       <= '0;
      skid_valid <= 1'b0;
`endif
    end else if (hold) begin
`ifdef FETCH_SKID_EN
      if (!skid_valid) begin
        skid       <= imem_rdata;
        skid_valid <= 1'b1;
      end
`endif
    end else begin
      fetched_pc <= pc_f;
      pc_f       <= pc_f + 16'd1;
      if (state == RUN) begin
`ifdef FETCH_SKID_EN
        ir         <= skid_valid ? skid : imem_rdata;
        skid_valid <= 1'b0;
`else
        ir         <= imem_rdata;
`endif
        ir_pc      <= fetched_pc;
        ir_valid   <= 1'b1;
      end else begin
        ir_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: two instances (RESET_PC 0 and FFFE) share stimulus, each with its own memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [15:0] redirect_pc;

  logic [15:0] addr0, rdata0, ir0, irpc0;
  logic        en0, v0;
  logic [2:0]  op0;
  logic [15:0] addrw, rdataw, irw, irpcw;
  logic        enw, vw;
  logic [2:0]  opw;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [15:0] exp_w;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .reset(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_addr(addr0), .imem_en(en0), .imem_rdata(rdata0),
    .ir(ir0), .opcode(op0), .ir_pc(irpc0), .ir_valid(v0)
  );

  fetch_unit #(.RESET_PC(16'hFFFE)) dut_w (
    .clk(clk), .reset(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_addr(addrw), .imem_en(enw), .imem_rdata(rdataw),
    .ir(irw), .opcode(opw), .ir_pc(irpcw), .ir_valid(vw)
  );

  function automatic logic [15:0] memw(input logic [15:0] a);
    return (a < 16'h0040) ? (16'h1000 + a) : (16'hE000 ^ a);
  endfunction

  always @(posedge clk) if (en0) rdata0 <= memw(addr0);
  always @(posedge clk) if (enw) rdataw <= memw(addrw);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    tick(); tick();
    n_checks++; if (ir0 !== 16'h0000) begin n_fail++; $display("FAIL rst_ir got %h exp 0000", ir0); end
    n_checks++; if (irpc0 !== 16'h0000) begin n_fail++; $display("FAIL rst_ir_pc got %h exp 0000", irpc0); end
    n_checks++; if (v0 !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", v0); end
    n_checks++; if (addr0 !== 16'h0000) begin n_fail++; $display("FAIL rst_addr got %h exp 0000", addr0); end
    n_checks++; if (en0 !== 1'b1) begin n_fail++; $display("FAIL rst_en got %b exp 1", en0); end
    n_checks++; if (addrw !== 16'hFFFE) begin n_fail++; $display("FAIL rst_addr_w got %h exp fffe", addrw); end
    rst = 1'b0;
    tick();
    n_checks++; if (v0 !== 1'b0) begin n_fail++; $display("FAIL boot_valid got %b exp 0", v0); end
    tick();
    n_checks++; if (ir0 !== 16'h1000) begin n_fail++; $display("FAIL first_ir got %h exp 1000", ir0); end
    n_checks++; if (irpc0 !== 16'h0000) begin n_fail++; $display("FAIL first_ir_pc got %h exp 0000", irpc0); end
    n_checks++; if (v0 !== 1'b1) begin n_fail++; $display("FAIL first_valid got %b exp 1", v0); end
    n_checks++; if (op0 !== 3'd0) begin n_fail++; $display("FAIL first_opcode got %0d exp 0", op0); end
  endtask

  task automatic test_stream;
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_checks++; if (ir0 !== 16'h1000 + 16'(k)) begin n_fail++; $display("FAIL stream_ir k=%0d got %h exp %h", k, ir0, 16'h1000 + 16'(k)); end
      n_checks++; if (irpc0 !== 16'(k)) begin n_fail++; $display("FAIL stream_ir_pc k=%0d got %h exp %h", k, irpc0, 16'(k)); end
    end
  endtask

  task automatic test_stall;
    stall = 1'b1;
    #1;
`ifdef FETCH_SKID_EN
    n_checks++; if (en0 !== 1'b1) begin n_fail++; $display("FAIL stall0_en got %b exp 1", en0); end
`else
    n_checks++; if (addr0 !== 16'h0005) begin n_fail++; $display("FAIL stall0_addr got %h exp 0005", addr0); end
`endif
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (ir0 !== 16'h1004) begin n_fail++; $display("FAIL stall_ir i=%0d got %h exp 1004", i, ir0); end
      n_checks++; if (irpc0 !== 16'h0004) begin n_fail++; $display("FAIL stall_ir_pc i=%0d got %h exp 0004", i, irpc0); end
      n_checks++; if (v0 !== 1'b1) begin n_fail++; $display("FAIL stall_valid i=%0d got %b exp 1", i, v0); end
`ifdef FETCH_SKID_EN
      n_checks++; if (en0 !== 1'b0) begin n_fail++; $display("FAIL stall_en i=%0d got %b exp 0", i, en0); end
`else
      n_checks++; if (addr0 !== 16'h0005) begin n_fail++; $display("FAIL stall_addr i=%0d got %h exp 0005", i, addr0); end
`endif
    end
    stall = 1'b0;
    tick();
    n_checks++; if (ir0 !== 16'h1005) begin n_fail++; $display("FAIL unstall_ir got %h exp 1005", ir0); end
    n_checks++; if (irpc0 !== 16'h0005) begin n_fail++; $display("FAIL unstall_ir_pc got %h exp 0005", irpc0); end
    n_checks++; if (addr0 !== 16'h0007) begin n_fail++; $display("FAIL unstall_addr got %h exp 0007", addr0); end
  endtask

  task automatic test_redirect(input logic with_stall, input logic [15:0] target);
    redirect = 1'b1; redirect_pc = target; stall = with_stall;
    tick();
    n_checks++; if (v0 !== 1'b0) begin n_fail++; $display("FAIL redir_r1_valid got %b exp 0", v0); end
    redirect = 1'b0; stall = 1'b0;
    tick();
    n_checks++; if (v0 !== 1'b0) begin n_fail++; $display("FAIL redir_r2_valid got %b exp 0", v0); end
    tick();
    exp_w = memw(target);
    n_checks++; if (ir0 !== exp_w) begin n_fail++; $display("FAIL redir_ir got %h exp %h", ir0, exp_w); end
    n_checks++; if (irpc0 !== target) begin n_fail++; $display("FAIL redir_ir_pc got %h exp %h", irpc0, target); end
    n_checks++; if (v0 !== 1'b1) begin n_fail++; $display("FAIL redir_valid got %b exp 1", v0); end
    n_checks++; if (op0 !== exp_w[15:13]) begin n_fail++; $display("FAIL redir_opcode got %0d exp %0d", op0, exp_w[15:13]); end
    tick();
    exp_w = memw(target + 16'd1);
    n_checks++; if (ir0 !== exp_w) begin n_fail++; $display("FAIL redir_next_ir got %h exp %h", ir0, exp_w); end
    n_checks++; if (irpc0 !== target + 16'd1) begin n_fail++; $display("FAIL redir_next_ir_pc got %h exp %h", irpc0, target + 16'd1); end
  endtask

  task automatic test_wrap;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(); tick();
    n_checks++; if (irpcw !== 16'hFFFE || irw !== 16'h1FFE) begin n_fail++; $display("FAIL wrap0 got pc %h ir %h exp fffe 1ffe", irpcw, irw); end
    tick();
    n_checks++; if (irpcw !== 16'hFFFF || irw !== 16'h1FFF) begin n_fail++; $display("FAIL wrap1 got pc %h ir %h exp ffff 1fff", irpcw, irw); end
    tick();
    n_checks++; if (irpcw !== 16'h0000 || irw !== 16'h1000 || vw !== 1'b1) begin n_fail++; $display("FAIL wrap2 got pc %h ir %h v %b exp 0000 1000 1", irpcw, irw, vw); end
  endtask

  task automatic test_reset_midstream;
    tick();
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (ir0 !== 16'h0000 || irpc0 !== 16'h0000 || v0 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_regs got %h %h %b exp 0000 0000 0", ir0, irpc0, v0); end
    n_checks++; if (addr0 !== 16'h0000 || en0 !== 1'b1) begin n_fail++; $display("FAIL mid_rst_imem got %h %b exp 0000 1", addr0, en0); end
    n_checks++; if (addrw !== 16'hFFFE || vw !== 1'b0) begin n_fail++; $display("FAIL mid_rst_w got %h %b exp fffe 0", addrw, vw); end
    tick();
    rst = 1'b0;
    tick(); tick();
    n_checks++; if (ir0 !== 16'h1000 || irpc0 !== 16'h0000 || v0 !== 1'b1) begin n_fail++; $display("FAIL restart got %h %h %b exp 1000 0000 1", ir0, irpc0, v0); end
    n_checks++; if (irw !== 16'h1FFE) begin n_fail++; $display("FAIL restart_w got %h exp 1ffe", irw); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect(1'b0, 16'h0040);
    test_redirect(1'b1, 16'h0010);
    test_wrap();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 16-bit CPU. Holds the program counter, drives a synchronous-read instruction memory, and registers each returned word into an instruction register. The opcode field feeds the control decoder directly downstream. Supports decode stalls and jump/branch redirects from execute.

## Interface

- RESET_PC, 16'h0000, PC value loaded on reset.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- stall  input  1  downstream not ready; hold `ir`, `ir_pc`, `ir_valid`.
- redirect  input  1  taken jump/branch; load `redirect_pc`.
- redirect_pc  input  16  redirect target.
- imem_addr  output  16  instruction memory address (combinational from state).
- imem_en  output  1  instruction memory read enable.
- imem_rdata  input  16  memory data; word for the address presented in the previous cycle.
- ir  output  16  registered instruction.
- opcode  output  3  `ir[15:13]`, to the control decoder.
- ir_pc  output  16  address of `ir`.
- ir_valid  output  1  `ir` holds a live instruction.

## Operation

- Registers:
  - `pc_f`: next address to present.
  - `fetched_pc`: address presented last cycle.
  - `state` ∈ {BOOT, RUN, REDIR}.
  - `ir`, `ir_pc`, `ir_valid`.
- Reset values: `pc_f` = RESET_PC, `fetched_pc` = RESET_PC, `state` = BOOT, `ir` = 16'h0000, `ir_pc` = 16'h0000, `ir_valid` = 0. `imem_en` = 1 and `imem_addr` = RESET_PC while in reset.
- BOOT:
  - Presents `pc_f`, then `fetched_pc` ← `pc_f`, `pc_f` ← `pc_f`+1.
  - `ir_valid` ← 0; `stall` is ignored.
  - Next state is RUN, or REDIR if `redirect`.
- RUN, no stall, no redirect:
  - `ir` ← `imem_rdata`, `ir_pc` ← `fetched_pc`, `ir_valid` ← 1.
  - Presents `pc_f`; `fetched_pc` ← `pc_f`, `pc_f` ← `pc_f`+1.
- RUN, stall (no redirect):
  - `ir`, `ir_pc`, `ir_valid` held; `pc_f` held.
  - The pending word is preserved (see Configuration).
- Redirect, in any state:
  - Overrides `stall`.
  - `pc_f` ← `redirect_pc`; `ir_valid` ← 0; next state is REDIR.
  - The word returning next cycle belongs to the old path and is discarded.
- REDIR:
  - Returned data is dropped; `ir_valid` ← 0.
  - Presents `pc_f`; `fetched_pc` ← `pc_f`, `pc_f` ← `pc_f`+1.
  - `stall` is ignored.
  - Next state is RUN, or REDIR again if `redirect`.
- Arithmetic: PC is modulo 2^16; 16'hFFFF+1 = 16'h0000 with no flag.
- Reset mid-operation: all registers return to reset values asynchronously; the in-flight memory word is ignored.

## Timing

- Fetch latency: address presented in cycle N, `ir`/`ir_valid` visible in cycle N+2.
- After reset release:
  - Edge 1: BOOT presents RESET_PC.
  - Edge 2: `ir` = mem[RESET_PC] becomes visible.
- Steady state without stalls: one instruction per cycle, `ir_pc` incrementing by 1.
- Redirect penalty: asserted in cycle R; `ir_valid` = 0 in cycles R+1 and R+2; `ir` = mem[target] with `ir_pc` = target visible in R+3.
- Stall: outputs frozen from the cycle after the stall is sampled. The first cycle after deassertion loads the instruction following the held one, with no lost or duplicated word.

## Configuration

- FETCH_SKID_EN undefined (replay mode):
  - During a RUN stall, `imem_addr` = `fetched_pc` and `imem_en` = 1.
  - Memory re-reads the pending word every cycle.
- FETCH_SKID_EN defined (skid mode):
  - A 16-bit skid register captures `imem_rdata` in the first stall cycle.
  - `imem_en` = 0 for the remaining stall cycles.
  - On stall release, `ir` loads from the skid register while `pc_f` is presented with `imem_en` = 1.
  - Redirect clears the skid register.
- The `ir` stream and its timing at the outputs are identical in both modes.

## Test plan

- Reset, mem[i] = 16'h1000+i, RESET_PC = 0 → `ir_valid` rises 2 edges after release; `ir` = 16'h1000, 16'h1001, …; `opcode` = `ir[15:13]`.
- Stall for 3 cycles while `ir` = 16'h1004 → `ir` holds 16'h1004, then 16'h1005 with no skip or duplicate. Check `imem_en` = 0 in skid mode and `imem_addr` = 5 in replay mode.
- Redirect to 16'h0040 while `pc_f` = 7 → two cycles with `ir_valid` = 0, then `ir_pc` = 16'h0040 and `ir` = mem[0x40].
- Redirect and stall in the same cycle → redirect wins; same result as the previous scenario.
- RESET_PC = 16'hFFFE → `ir_pc` sequence FFFE, FFFF, 0000.
- Assert reset mid-stream between edges → outputs return to reset values immediately; restart fetches from RESET_PC.
